// File: rtl/regfile_32x32_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : regfile_32x32_pkg                                         |
// | Brief  : Shared sizing constants for the 32x32 register file.      |
// | Rev    : 1.0                                                       |
// +--------------------------------------------------------------------+
package regfile_32x32_pkg;
    localparam int REG_COUNT = 32;
    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 32;
endpackage : regfile_32x32_pkg
`default_nettype wire

// File: rtl/regfile_32x32_mux32_32x1.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : mux32_32x1                                                |
// | Brief  : 32-way selector of 32-bit words.                          |
// | Rev    : 1.0                                                       |
// +--------------------------------------------------------------------+
module mux32_32x1
    import regfile_32x32_pkg::*;
(
    input  logic [REG_COUNT-1:0][DATA_W-1:0] data_i,
    input  logic [ADDR_W-1:0]                sel_i,
    output logic [DATA_W-1:0]                y_o
);
    assign y_o = data_i[sel_i];
endmodule : mux32_32x1
`default_nettype wire

// File: rtl/regfile_32x32_register32.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : register32                                                |
// | Brief  : 32-bit register with synchronous reset and load enable.   |
// | Rev    : 1.0                                                       |
// +--------------------------------------------------------------------+
module register32
    import regfile_32x32_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o
);
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (en_i) begin
            data_d = d_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;
endmodule : register32
`default_nettype wire

// File: rtl/regfile_32x32.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : regfile_32x32                                             |
// | Brief  : 2R/1W register file with write forwarding and a pending-  |
// |          write scoreboard.                                         |
// | Rev    : 1.0                                                       |
// +--------------------------------------------------------------------+
module regfile_32x32
    import regfile_32x32_pkg::*;
#(
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              rd_pend1,
    output logic              rd_pend2,
    output logic              stall
);
    localparam bit c_bypass_en = (BYPASS != 0);
    localparam bit c_zero_reg  = (ZERO_REG != 0);

    logic [REG_COUNT-1:0]             w_wr_sel;
    logic [REG_COUNT-1:0][DATA_W-1:0] w_regs;
    logic [DATA_W-1:0]                w_mux1;
    logic [DATA_W-1:0]                w_mux2;
    logic                             w_rd1_zero;
    logic                             w_rd2_zero;
    logic                             w_fwd1;
    logic                             w_fwd2;
    logic [REG_COUNT-1:0]             pend_q;
    logic [REG_COUNT-1:0]             pend_d;

    genvar gi;
    generate
        for (gi = 0; gi < REG_COUNT; gi++) begin : g_entry
            // Entry 0 is never enabled when hardwired, so it stays at its reset value.
            assign w_wr_sel[gi] = wr_en && (wr_addr == ADDR_W'(gi)) && !(c_zero_reg && (gi == 0));

            register32 u_reg (
                .clk  (clk),
                .rst  (rst),
                .en_i (w_wr_sel[gi]),
                .d_i  (wr_data),
                .q_o  (w_regs[gi])
            );
        end
    endgenerate

    mux32_32x1 u_mux1 (.data_i(w_regs), .sel_i(rd_addr1), .y_o(w_mux1));
    mux32_32x1 u_mux2 (.data_i(w_regs), .sel_i(rd_addr2), .y_o(w_mux2));

    assign w_rd1_zero = c_zero_reg && (rd_addr1 == '0);
    assign w_rd2_zero = c_zero_reg && (rd_addr2 == '0);
    assign w_fwd1     = c_bypass_en && wr_en && (wr_addr == rd_addr1) && !w_rd1_zero;
    assign w_fwd2     = c_bypass_en && wr_en && (wr_addr == rd_addr2) && !w_rd2_zero;

    assign rd_data1 = w_fwd1 ? wr_data : (w_rd1_zero ? '0 : w_mux1);
    assign rd_data2 = w_fwd2 ? wr_data : (w_rd2_zero ? '0 : w_mux2);

    // Set is applied after clear so a same-cycle reserve of the written index wins.
    always_comb begin
        pend_d = pend_q;
        if (wr_en) begin
            pend_d[wr_addr] = 1'b0;
        end
        if (rsv_en && !(c_zero_reg && (rsv_addr == '0))) begin
            pend_d[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign rd_pend1 = pend_q[rd_addr1] && !w_fwd1;
    assign rd_pend2 = pend_q[rd_addr2] && !w_fwd2;
    assign stall    = rd_pend1 || rd_pend2;
endmodule : regfile_32x32
`default_nettype wire

// File: tb/tb_regfile_32x32.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : tb_regfile_32x32                                          |
// | Brief  : Vector table plus scoreboard bench for regfile_32x32.     |
// | Rev    : 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_regfile_32x32;
    logic        clk = 1'b0;
    logic        rst, wr_en, rsv_en;
    logic [4:0]  wr_addr, rsv_addr, rd_addr1, rd_addr2;
    logic [31:0] wr_data;
    logic [31:0] d1a, d2a, d1b, d2b;
    logic        p1a, p2a, sta, p1b, p2b, stb;

    always #5 clk = ~clk;

    regfile_32x32 #(.BYPASS(1), .ZERO_REG(1)) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(d1a), .rd_data2(d2a),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_pend1(p1a), .rd_pend2(p2a), .stall(sta)
    );

    regfile_32x32 #(.BYPASS(0), .ZERO_REG(0)) u_nobyp (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(d1b), .rd_data2(d2b),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_pend1(p1b), .rd_pend2(p2b), .stall(stb)
    );

    typedef struct packed {
        logic [31:0] d1;
        logic [31:0] d2;
        logic        p1;
        logic        p2;
        logic        st;
    } out_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        re;
        logic [4:0]  ra;
        logic [4:0]  a1;
        logic [4:0]  a2;
        out_t        e;
    } vec_t;

    out_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic out_t mo(input logic [31:0] d1, input logic [31:0] d2,
                                input logic p1, input logic p2, input logic st);
        out_t o;
        o.d1 = d1; o.d2 = d2; o.p1 = p1; o.p2 = p2; o.st = st;
        return o;
    endfunction

    function automatic vec_t mv(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic re, input logic [4:0] ra,
                                input logic [4:0] a1, input logic [4:0] a2, input out_t e);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra; v.a1 = a1; v.a2 = a2; v.e = e;
        return v;
    endfunction

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic re, input logic [4:0] ra,
                         input logic [4:0] a1, input logic [4:0] a2, input logic r);
        rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
        rsv_en = re; rsv_addr = ra; rd_addr1 = a1; rd_addr2 = a2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for the mid-cycle sample point, then compares against the oldest expectation.
    task automatic sample(input string nm);
        out_t e;
        @(negedge clk);
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = sb_q.pop_front();
            check32({nm, ".d1"}, d1a, e.d1);
            check32({nm, ".d2"}, d2a, e.d2);
            check32({nm, ".p1"}, {31'd0, p1a}, {31'd0, e.p1});
            check32({nm, ".p2"}, {31'd0, p2a}, {31'd0, e.p2});
            check32({nm, ".st"}, {31'd0, sta}, {31'd0, e.st});
        end
    endtask

    vec_t vt[19];

    initial begin
        vt[0]  = mv(0, 0,  0,            0, 0,  5, 31, mo(0, 0, 0, 0, 0));
        vt[1]  = mv(1, 5,  32'hDEADBEEF, 0, 0,  0,  1, mo(0, 0, 0, 0, 0));
        vt[2]  = mv(0, 0,  0,            0, 0,  5,  5, mo(32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0));
        vt[3]  = mv(1, 0,  32'h12345678, 0, 0,  0,  0, mo(0, 0, 0, 0, 0));
        vt[4]  = mv(0, 0,  0,            1, 0,  0,  5, mo(0, 32'hDEADBEEF, 0, 0, 0));
        vt[5]  = mv(0, 0,  0,            0, 0,  0,  0, mo(0, 0, 0, 0, 0));
        vt[6]  = mv(0, 0,  0,            1, 3,  3,  5, mo(0, 32'hDEADBEEF, 0, 0, 0));
        vt[7]  = mv(0, 0,  0,            0, 0,  3,  4, mo(0, 0, 1, 0, 1));
        vt[8]  = mv(1, 3,  32'h55,       0, 0,  5,  3, mo(32'hDEADBEEF, 32'h55, 0, 0, 0));
        vt[9]  = mv(0, 0,  0,            0, 0,  3,  3, mo(32'h55, 32'h55, 0, 0, 0));
        vt[10] = mv(1, 7,  32'hA5A5A5A5, 0, 0,  7,  8, mo(32'hA5A5A5A5, 0, 0, 0, 0));
        vt[11] = mv(1, 9,  32'h99,       1, 9,  9,  9, mo(32'h99, 32'h99, 0, 0, 0));
        vt[12] = mv(0, 0,  0,            0, 0,  9,  7, mo(32'h99, 32'hA5A5A5A5, 1, 0, 1));
        vt[13] = mv(0, 0,  0,            1, 9,  9,  9, mo(32'h99, 32'h99, 1, 1, 1));
        vt[14] = mv(0, 0,  0,            0, 0,  9,  0, mo(32'h99, 0, 1, 0, 1));
        vt[15] = mv(1, 9,  32'h100,      0, 0,  2,  9, mo(0, 32'h100, 0, 0, 0));
        vt[16] = mv(0, 0,  0,            0, 0,  9,  9, mo(32'h100, 32'h100, 0, 0, 0));
        vt[17] = mv(1, 12, 32'hC,        0, 0, 12, 12, mo(32'hC, 32'hC, 0, 0, 0));
        vt[18] = mv(0, 0,  0,            0, 0, 12, 12, mo(32'hC, 32'hC, 0, 0, 0));

        drive(0, 0, 0, 0, 0, 0, 0, 1);
        step();
        step();

        for (int i = 0; i < 19; i++) begin
            drive(vt[i].we, vt[i].wa, vt[i].wd, vt[i].re, vt[i].ra, vt[i].a1, vt[i].a2, 0);
            sb_q.push_back(vt[i].e);
            sample($sformatf("vec%0d", i));
            step();
        end

        // Forwarding versus no forwarding on the same write.
        drive(1, 7, 32'h11111111, 0, 0, 7, 0, 0);
        sb_q.push_back(mo(32'h11111111, 0, 0, 0, 0));
        sample("fwd");
        check32("nobyp.old", d1b, 32'hA5A5A5A5);
        step();
        drive(0, 0, 0, 0, 0, 7, 7, 0);
        sb_q.push_back(mo(32'h11111111, 32'h11111111, 0, 0, 0));
        sample("fwd.after");
        check32("nobyp.new", d1b, 32'h11111111);
        step();
        // r0 is an ordinary, still-reserved register when not hardwired.
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        sb_q.push_back(mo(0, 0, 0, 0, 0));
        sample("r0");
        check32("nobyp.r0", d1b, 32'h12345678);
        check32("nobyp.r0pend", {31'd0, p1b}, 32'd1);
        step();

        // Fill, reserve, then reset with competing write/reserve.
        for (int i = 1; i < 32; i++) begin
            drive(1, 5'(i), 32'(i), 0, 0, 0, 0, 0);
            step();
        end
        drive(0, 0, 0, 1, 10, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 10, 1, 0);
        sb_q.push_back(mo(32'd10, 32'd1, 1, 0, 1));
        sample("filled");
        step();
        drive(1, 4, 32'hFFFFFFFF, 1, 4, 0, 0, 1);
        step();
        for (int i = 0; i < 32; i++) begin
            drive(0, 0, 0, 0, 0, 5'(i), 5'(31 - i), 0);
            sb_q.push_back(mo(0, 0, 0, 0, 0));
            sample($sformatf("postrst%0d", i));
            check32($sformatf("nobyp.postrst%0d", i), d1b, 32'd0);
            check32($sformatf("nobyp.stall%0d", i), {31'd0, stb}, 32'd0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule : tb_regfile_32x32
`default_nettype wire
